// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: state encoding,
// coin index constants and denomination lookup.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  localparam logic [1:0] COIN0 = 2'd0;
  localparam logic [1:0] COIN1 = 2'd1;
  localparam logic [1:0] COIN2 = 2'd2;
  localparam logic [1:0] COIN3 = 2'd3;

  // Denomination values are module parameters, so they are passed in.
  function automatic int coin_value(input logic [1:0] sel,
                                    input int v0, input int v1,
                                    input int v2, input int v3);
    int v;
    case (sel)
      COIN0:   v = v0;
      COIN1:   v = v1;
      COIN2:   v = v2;
      default: v = v3;
    endcase
    return v;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Change-count register: loads owed units, emits one change pulse per unit while run is high.
// Latency: pulse in the first run cycle after load; no backpressure, one unit per cycle.
module change_dispenser #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         change_pulse,
  output logic         done,
  output logic         pending
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (run && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign change_pulse = run && (count_q != '0);
  // done flags the last unit: the count reaches zero at the coming edge.
  assign done    = (count_q <= W'(1));
  assign pending = (count_q != '0);

endmodule

// File: rtl/vend_controller.sv
// Vending controller: accumulates coin credit against PRICE, vends, then returns change.
// Latency: vend one cycle after the completing coin; coins outside IDLE/COLLECT are rejected.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE     = 3,
  parameter int COIN0_VAL = 1,
  parameter int COIN1_VAL = 2,
  parameter int COIN2_VAL = 5,
  parameter int COIN3_VAL = 10,
  parameter int CREDIT_W  = 5,
  parameter int SALES_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  output logic                ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [SALES_W-1:0]  sales
);

  localparam int MAX_COIN = max4(COIN0_VAL, COIN1_VAL, COIN2_VAL, COIN3_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  if (PRICE < 1) begin : g_price_check
    $error("vend_controller: PRICE must be at least 1");
  end
  if ((PRICE - 1 + MAX_COIN) > ((1 << CREDIT_W) - 1)) begin : g_credit_w_check
    $error("vend_controller: CREDIT_W too narrow for PRICE-1+max coin value");
  end

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [SALES_W-1:0]    sales_q, sales_d;
  logic                  coin_reject_q, coin_reject_d;

  logic [CREDIT_W-1:0]   coin_v;
  logic [CREDIT_W-1:0]   sum;
  logic                  chg_load;
  logic [CREDIT_W-1:0]   chg_load_val;
  logic                  chg_run;
  logic                  chg_done;
  logic                  chg_pending;

  assign coin_v  = CREDIT_W'(coin_value(coin_sel, COIN0_VAL, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign sum     = credit_q + coin_v;
  assign chg_run = (state_q == REFUND);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    sales_d       = sales_q;
    coin_reject_d = 1'b0;
    chg_load      = 1'b0;
    chg_load_val  = '0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          coin_reject_d = enable;
          if (credit_q != '0) begin
            chg_load     = 1'b1;
            chg_load_val = credit_q;
            credit_d     = '0;
            state_d      = REFUND;
          end
        end else if (enable) begin
          if (sum < PRICE_C) begin
            credit_d = sum;
            state_d  = COLLECT;
          end else begin
            chg_load     = 1'b1;
            chg_load_val = sum - PRICE_C;
            credit_d     = '0;
            state_d      = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = enable;
        sales_d       = sales_q + 1'b1;
        state_d       = chg_pending ? REFUND : IDLE;
      end
      REFUND: begin
        coin_reject_d = enable;
        if (chg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      sales_q       <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      sales_q       <= sales_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  change_dispenser #(.W(CREDIT_W)) u_change (
    .clk          (clk),
    .reset        (reset),
    .load         (chg_load),
    .load_val     (chg_load_val),
    .run          (chg_run),
    .change_pulse (change_pulse),
    .done         (chg_done),
    .pending      (chg_pending)
  );

  assign ready       = (state_q == IDLE) || (state_q == COLLECT);
  assign credit      = credit_q;
  assign vend        = (state_q == DISPENSE);
  assign coin_reject = coin_reject_q;
  assign sales       = sales_q;

endmodule
